// File: rtl/pipe_cla_adder.sv
// Pipelined block-carry adder/subtractor: one BLOCK-bit lookahead slice per stage,
// with the inter-block carry registered and valid/ready flow control.
module pipe_cla_adder #(
  parameter int WIDTH = 32,
  parameter int BLOCK = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             sub,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] S,
  output logic             cout,
  output logic             ovf
);

  localparam int STAGES = WIDTH / BLOCK;

  if (!(BLOCK == 4 || BLOCK == 8 || BLOCK == 16) || (WIDTH % BLOCK) != 0) begin : g_param_check
    $error("pipe_cla_adder: WIDTH must be a multiple of BLOCK, BLOCK must be 4, 8 or 16");
  end

  // Returns {carry_out, sum}; carries come from group generate/propagate terms.
  function automatic logic [BLOCK:0] slice_add(input logic [BLOCK-1:0] a,
                                               input logic [BLOCK-1:0] b,
                                               input logic             ci);
    logic [BLOCK-1:0] g;
    logic [BLOCK-1:0] p;
    logic [BLOCK:0]   c;
    logic             gg;
    logic             pp;
    g    = a & b;
    p    = a ^ b;
    gg   = 1'b0;
    pp   = 1'b1;
    c[0] = ci;
    for (int i = 0; i < BLOCK; i++) begin
      gg     = g[i] | (p[i] & gg);
      pp     = pp & p[i];
      c[i+1] = gg | (pp & ci);
    end
    return {c[BLOCK], p ^ c[BLOCK-1:0]};
  endfunction

  logic              advance;
  logic [STAGES-1:0] valid_reg;
  logic [WIDTH-1:0]  be;
  logic              c0;

  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;
  assign be       = sub ? ~B : B;
  assign c0       = sub | cin;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      valid_reg <= '0;
    end else if (flush) begin
      valid_reg <= '0;
    end else if (advance) begin
      valid_reg <= (valid_reg << 1) | STAGES'(in_valid);
    end
  end

  for (genvar gi = 0; gi < STAGES; gi++) begin : stg
    localparam int LO = gi * BLOCK;
    localparam int HI = LO + BLOCK;

    logic [BLOCK-1:0] a_in;
    logic [BLOCK-1:0] b_in;
    logic             c_in;
    logic [BLOCK:0]   res;
    logic [HI-1:0]    sum_next;
    logic [HI-1:0]    sum_reg;
    logic             carry_reg;

    if (gi == 0) begin : g_src
      assign a_in     = A[BLOCK-1:0];
      assign b_in     = be[BLOCK-1:0];
      assign c_in     = c0;
      assign sum_next = res[BLOCK-1:0];
    end else begin : g_src
      assign a_in     = stg[gi-1].g_up.a_up_reg[BLOCK-1:0];
      assign b_in     = stg[gi-1].g_up.b_up_reg[BLOCK-1:0];
      assign c_in     = stg[gi-1].carry_reg;
      assign sum_next = {res[BLOCK-1:0], stg[gi-1].sum_reg};
    end

    assign res = slice_add(a_in, b_in, c_in);

    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        sum_reg   <= '0;
        carry_reg <= 1'b0;
      end else if (advance) begin
        sum_reg   <= sum_next;
        carry_reg <= res[BLOCK];
      end
    end

    // Operand bits not yet consumed; this store narrows by BLOCK every stage.
    if (gi < STAGES - 1) begin : g_up
      logic [WIDTH-HI-1:0] a_up_reg;
      logic [WIDTH-HI-1:0] b_up_reg;
      logic [WIDTH-HI-1:0] a_up_next;
      logic [WIDTH-HI-1:0] b_up_next;

      if (gi == 0) begin : g_ld
        assign a_up_next = A[WIDTH-1:HI];
        assign b_up_next = be[WIDTH-1:HI];
      end else begin : g_ld
        assign a_up_next = stg[gi-1].g_up.a_up_reg[WIDTH-LO-1:BLOCK];
        assign b_up_next = stg[gi-1].g_up.b_up_reg[WIDTH-LO-1:BLOCK];
      end

      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
          a_up_reg <= '0;
          b_up_reg <= '0;
        end else if (advance) begin
          a_up_reg <= a_up_next;
          b_up_reg <= b_up_next;
        end
      end
    end

    // Carry into the MSB recovered from the MSB's own operand and sum bits.
    if (gi == STAGES - 1) begin : g_last
      logic cmsb_reg;
      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
          cmsb_reg <= 1'b0;
        end else if (advance) begin
          cmsb_reg <= a_in[BLOCK-1] ^ b_in[BLOCK-1] ^ res[BLOCK-1];
        end
      end
    end
  end

  assign out_valid = valid_reg[STAGES-1];
  assign S         = stg[STAGES-1].sum_reg;
  assign cout      = stg[STAGES-1].carry_reg;
  assign ovf       = stg[STAGES-1].g_last.cmsb_reg ^ stg[STAGES-1].carry_reg;

endmodule

// File: tb/tb_pipe_cla_adder.sv
// Scoreboard bench: a 32/8 and a 16/4 instance run in lockstep on shared stimulus.
module tb_pipe_cla_adder;
  localparam int STAGES = 4;

  typedef struct packed {
    logic [31:0] s;
    logic        co;
    logic        ov;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic        sub = 1'b0;
  logic        cin = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;

  logic        in_ready32, out_valid32, cout32, ovf32;
  logic [31:0] s32;
  logic        in_ready16, out_valid16, cout16, ovf16;
  logic [15:0] s16;

  logic        rdy[2];
  logic        ov_a[2];
  logic [31:0] s_a[2];
  logic        co_a[2];
  logic        of_a[2];

  assign rdy[0] = in_ready32;   assign rdy[1] = in_ready16;
  assign ov_a[0] = out_valid32; assign ov_a[1] = out_valid16;
  assign s_a[0] = s32;          assign s_a[1] = {16'h0, s16};
  assign co_a[0] = cout32;      assign co_a[1] = cout16;
  assign of_a[0] = ovf32;       assign of_a[1] = ovf16;

  always #5 clock = ~clock;

  pipe_cla_adder #(.WIDTH(32), .BLOCK(8)) u_dut32 (
    .clock(clock), .reset_n(reset_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready32),
    .A(a), .B(b), .sub(sub), .cin(cin), .out_valid(out_valid32), .out_ready(out_ready),
    .S(s32), .cout(cout32), .ovf(ovf32));

  pipe_cla_adder #(.WIDTH(16), .BLOCK(4)) u_dut16 (
    .clock(clock), .reset_n(reset_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready16),
    .A(a[15:0]), .B(b[15:0]), .sub(sub), .cin(cin), .out_valid(out_valid16), .out_ready(out_ready),
    .S(s16), .cout(cout16), .ovf(ovf16));

  int   checks = 0;
  int   errors = 0;
  exp_t q[2][$];
  int   pops[2];
  bit   held[2];
  logic [31:0] hs[2];
  logic hc[2];
  logic ho[2];
  bit   rand_ready = 0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endfunction

  // Reference: integer arithmetic on the operands, signed range test for overflow.
  function automatic exp_t model(int w, logic [31:0] av32, logic [31:0] bv32, logic is_sub, logic ci);
    longint unsigned mask, av, bv, sum;
    longint sa, sbv, sr, lim;
    exp_t r;
    mask = (longint'(1) << w) - 1;
    av = 64'(av32) & mask;
    bv = 64'(bv32) & mask;
    sa = longint'(av);
    if (av[w-1]) sa = sa - (longint'(1) << w);
    sbv = longint'(bv);
    if (bv[w-1]) sbv = sbv - (longint'(1) << w);
    lim = longint'(1) << (w - 1);
    if (is_sub) begin
      r.co = (av >= bv);
      r.s  = 32'((av - bv) & mask);
      sr   = sa - sbv;
    end else begin
      sum  = av + bv + 64'(ci);
      r.co = sum[w];
      r.s  = 32'(sum & mask);
      sr   = sa + sbv + longint'(ci);
    end
    r.ov = (sr >= lim) || (sr < -lim);
    return r;
  endfunction

  // Monitor: pops on every output handshake and checks hold stability under stall.
  always @(negedge clock) begin
    exp_t e;
    for (int d = 0; d < 2; d++) begin
      if (!reset_n) begin
        held[d] = 0;
      end else begin
        if (held[d]) begin
          chk($sformatf("dut%0d_hold_valid", d), 64'(ov_a[d]), 64'd1);
          chk($sformatf("dut%0d_hold_S", d), 64'(s_a[d]), 64'(hs[d]));
          chk($sformatf("dut%0d_hold_cout", d), 64'(co_a[d]), 64'(hc[d]));
          chk($sformatf("dut%0d_hold_ovf", d), 64'(of_a[d]), 64'(ho[d]));
        end
        if (ov_a[d] && out_ready) begin
          if (q[d].size() == 0) begin
            checks++;
            errors++;
            $display("FAIL dut%0d_spurious: out_valid=1 S=0x%0h, expected no result", d, s_a[d]);
          end else begin
            e = q[d].pop_front();
            chk($sformatf("dut%0d_S", d), 64'(s_a[d]), 64'(e.s));
            chk($sformatf("dut%0d_cout", d), 64'(co_a[d]), 64'(e.co));
            chk($sformatf("dut%0d_ovf", d), 64'(of_a[d]), 64'(e.ov));
            pops[d]++;
          end
        end
        held[d] = ov_a[d] && !out_ready;
        hs[d] = s_a[d];
        hc[d] = co_a[d];
        ho[d] = of_a[d];
      end
    end
  end

  always @(posedge clock) begin
    #2;
    if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
  end

  task automatic issue(input logic [31:0] ia, input logic [31:0] ib, input logic is, input logic ic,
                       input bit has_exp = 0, input exp_t e32 = '0);
    int n = 0;
    @(posedge clock); #1;
    a = ia; b = ib; sub = is; cin = ic; in_valid = 1'b1;
    forever begin
      @(negedge clock);
      if (rdy[0]) begin
        q[0].push_back(has_exp ? e32 : model(32, ia, ib, is, ic));
        if (rdy[1]) q[1].push_back(model(16, ia, ib, is, ic));
        break;
      end
      n++;
      if (n > 200) begin
        checks++;
        errors++;
        $display("FAIL issue_timeout: in_ready=0 for %0d cycles, expected acceptance", n);
        break;
      end
      @(posedge clock); #1;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clock); #1;
      in_valid = 1'b0;
    end
  endtask

  task automatic chk_zero(input string name);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("%s_dut%0d_out_valid", name, d), 64'(ov_a[d]), 64'd0);
      chk($sformatf("%s_dut%0d_S", name, d), 64'(s_a[d]), 64'd0);
      chk($sformatf("%s_dut%0d_cout", name, d), 64'(co_a[d]), 64'd0);
      chk($sformatf("%s_dut%0d_ovf", name, d), 64'(of_a[d]), 64'd0);
      chk($sformatf("%s_dut%0d_in_ready", name, d), 64'(rdy[d]), 64'd1);
    end
  endtask

  task automatic expect_quiet(input string name, input int n);
    repeat (n) begin
      @(negedge clock);
      chk($sformatf("%s_dut0_out_valid", name), 64'(ov_a[0]), 64'd0);
      chk($sformatf("%s_dut1_out_valid", name), 64'(ov_a[1]), 64'd0);
    end
  endtask

  initial begin
    int base;
    // Reset held with random inputs.
    for (int i = 0; i < 3; i++) begin
      @(posedge clock); #1;
      a = $urandom; b = $urandom; sub = 1'($urandom); cin = 1'($urandom); in_valid = 1'($urandom);
      @(negedge clock);
      chk_zero("reset");
    end
    #2 reset_n = 1'b1;
    in_valid = 1'b0;
    chk_zero("post_reset");
    expect_quiet("reset_idle", 5);

    // Full carry chain, with an exact latency check.
    issue(32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 1, '{s: 32'h0, co: 1'b1, ov: 1'b0});
    @(posedge clock); #1;
    in_valid = 1'b0;
    for (int k = 0; k < STAGES; k++) begin
      @(negedge clock);
      chk($sformatf("latency_k%0d_dut0", k), 64'(ov_a[0]), 64'(k == STAGES - 1));
      chk($sformatf("latency_k%0d_dut1", k), 64'(ov_a[1]), 64'(k == STAGES - 1));
    end
    issue(32'h0, 32'h0, 1'b0, 1'b1, 1, '{s: 32'h1, co: 1'b0, ov: 1'b0});
    issue(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, 1, '{s: 32'h8000_0000, co: 1'b0, ov: 1'b1});
    issue(32'h8000_0000, 32'h1, 1'b1, 1'b0, 1, '{s: 32'h7FFF_FFFF, co: 1'b1, ov: 1'b1});
    issue(32'h5, 32'h7, 1'b1, 1'b1, 1, '{s: 32'hFFFF_FFFE, co: 1'b0, ov: 1'b0});
    issue(32'h7, 32'h5, 1'b1, 1'b0, 1, '{s: 32'h2, co: 1'b1, ov: 1'b0});
    idle(STAGES + 2);

    // Backpressure: 8 back-to-back ops, out_ready dropped for 3 cycles after the 2nd result.
    base = pops[0];
    fork
      begin
        for (int i = 0; i < 8; i++) issue(32'(i), 32'(i) << 24, 1'b0, 1'b0);
        idle(1);
      end
      begin
        int guard = 0;
        while (pops[0] < base + 2 && guard < 100) begin
          @(posedge clock);
          guard++;
        end
        if (guard >= 100) begin
          checks++;
          errors++;
          $display("FAIL bp_wait: saw %0d results, expected 2 before timeout", pops[0] - base);
        end
        #1 out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
          @(negedge clock);
          chk($sformatf("bp_stall%0d_in_ready_dut0", k), 64'(rdy[0]), 64'd0);
          chk($sformatf("bp_stall%0d_in_ready_dut1", k), 64'(rdy[1]), 64'd0);
        end
        @(posedge clock); #1;
        out_ready = 1'b1;
        @(negedge clock);
        chk("bp_release_in_ready", 64'(rdy[0]), 64'd1);
      end
    join
    idle(STAGES + 4);
    chk("bp_result_count", 64'(pops[0] - base), 64'd8);
    chk("bp_queue_empty", 64'(q[0].size()), 64'd0);

    // Flush with 3 ops in flight and a concurrent input handshake.
    for (int i = 0; i < 3; i++) issue($urandom, $urandom, 1'($urandom), 1'($urandom));
    @(posedge clock); #1;
    flush = 1'b1; in_valid = 1'b1; a = $urandom; b = $urandom;
    @(posedge clock);
    q[0].delete();
    q[1].delete();
    #1 flush = 1'b0;
    in_valid = 1'b0;
    expect_quiet("flush", STAGES + 2);
    issue(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 1, '{s: 32'h2345_6789, co: 1'b0, ov: 1'b0});
    idle(STAGES + 2);

    // Asynchronous reset while a result is being held at the output.
    out_ready = 1'b0;
    issue(32'hF000_0001, 32'h2000_0001, 1'b0, 1'b0);
    issue(32'hDEAD_BEEF, 32'h4000_0000, 1'b0, 1'b1);
    issue(32'h0000_0009, 32'h0000_0003, 1'b1, 1'b0);
    idle(1);
    begin
      int n = 0;
      while (!ov_a[0] && n < 20) begin
        @(negedge clock);
        n++;
      end
      chk("midreset_output_present", 64'(ov_a[0]), 64'd1);
    end
    @(posedge clock); #3;
    reset_n = 1'b0;
    q[0].delete();
    q[1].delete();
    #1 chk_zero("midreset");
    @(negedge clock);
    @(negedge clock); #2;
    reset_n = 1'b1;
    out_ready = 1'b1;
    expect_quiet("after_midreset", STAGES + 4);

    // Random traffic with random backpressure.
    rand_ready = 1;
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 3) == 0) idle(1);
      else issue($urandom, $urandom, 1'($urandom), 1'($urandom));
    end
    idle(1);
    rand_ready = 0;
    out_ready = 1'b1;
    idle(STAGES + 6);
    chk("final_queue32_empty", 64'(q[0].size()), 64'd0);
    chk("final_queue16_empty", 64'(q[1].size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
